// File: rtl/commutative_sweep_checker.sv
// commutative_sweep_checker
// Walks the gate-law block through all four A/B combinations, holds each for
// SETTLE_CYCLES clocks, then checks both commutative laws and the golden
// AND/OR values. Per-vector failures are reported through a start/done handshake.
module commutative_sweep_checker #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       and_lhs,
    input  logic       and_rhs,
    input  logic       or_lhs,
    input  logic       or_rhs,
    output logic       A,
    output logic       B,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_vec,
    output logic [2:0] err_cnt
);

    // A setting of 0 is treated as 1 so that every vector is held for at least one cycle.
    localparam int unsigned SETTLE_EFF = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
    localparam logic [3:0]  RELOAD     = 4'(SETTLE_EFF - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] CHECK  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0] state;
    logic [1:0] idx;
    logic [1:0] idx_next;
    logic [3:0] cnt;
    logic       vec_fail;
    logic [2:0] err_next;

    // Verdict for the vector currently applied, plus the error count it would produce.
    always_comb begin
        vec_fail = (and_lhs != and_rhs) ||
                   (or_lhs  != or_rhs)  ||
                   (and_lhs != (A & B)) ||
                   (or_lhs  != (A | B));
        err_next = err_cnt + {2'b00, vec_fail};
        idx_next = idx + 2'd1;
    end

    // Sweep sequencer: launch, settle, sample, advance, and hold the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            cnt      <= '0;
            A        <= 1'b0;
            B        <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            fail_vec <= '0;
            err_cnt  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= SETTLE;
                        idx      <= '0;
                        A        <= 1'b0;
                        B        <= 1'b0;
                        fail_vec <= '0;
                        err_cnt  <= '0;
                        pass     <= 1'b0;
                        done     <= 1'b0;
                        busy     <= 1'b1;
                        cnt      <= RELOAD;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        state <= CHECK;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                CHECK: begin
                    if (vec_fail) begin
                        fail_vec[idx] <= 1'b1;
                    end
                    err_cnt <= err_next;
                    if (idx != 2'd3) begin
                        // The next vector is driven on the same edge that records this verdict.
                        idx   <= idx_next;
                        A     <= idx_next[0];
                        B     <= idx_next[1];
                        cnt   <= RELOAD;
                        state <= SETTLE;
                    end else begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_commutative_sweep_checker.sv
// Bench for commutative_sweep_checker: two instances (default settle and
// SETTLE_CYCLES=1), each driving a behavioural gate-law block with selectable faults.
module tb_commutative_sweep_checker;

    typedef struct {
        logic [3:0] fv;
        logic [2:0] ec;
        logic       ps;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] start_s;
    logic [1:0] a_s, b_s, busy_s, done_s, pass_s;
    logic [1:0] andl_s, andr_s, orl_s, orr_s;
    logic [3:0] fv0, fv1;
    logic [2:0] ec0, ec1;
    int unsigned fault;

    int n_vec;
    int n_bad;
    exp_t sb[$];

    commutative_sweep_checker dut (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]),
        .and_lhs(andl_s[0]), .and_rhs(andr_s[0]), .or_lhs(orl_s[0]), .or_rhs(orr_s[0]),
        .A(a_s[0]), .B(b_s[0]), .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
        .fail_vec(fv0), .err_cnt(ec0)
    );

    commutative_sweep_checker #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]),
        .and_lhs(andl_s[1]), .and_rhs(andr_s[1]), .or_lhs(orl_s[1]), .or_rhs(orr_s[1]),
        .A(a_s[1]), .B(b_s[1]), .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
        .fail_vec(fv1), .err_cnt(ec1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural gate-law block. Fault 1: and_rhs stuck 0; 2: or_rhs = A&B; 3: both ANDs = A|B.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            andl_s[i] = a_s[i] & b_s[i];
            andr_s[i] = a_s[i] & b_s[i];
            orl_s[i]  = a_s[i] | b_s[i];
            orr_s[i]  = a_s[i] | b_s[i];
            case (fault)
                1: andr_s[i] = 1'b0;
                2: orr_s[i]  = a_s[i] & b_s[i];
                3: begin
                    andl_s[i] = a_s[i] | b_s[i];
                    andr_s[i] = a_s[i] | b_s[i];
                end
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {A, B, busy, done, pass, fail_vec, err_cnt}
    function automatic logic [11:0] outs(input int w);
        if (w == 0) return {a_s[0], b_s[0], busy_s[0], done_s[0], pass_s[0], fv0, ec0};
        return {a_s[1], b_s[1], busy_s[1], done_s[1], pass_s[1], fv1, ec1};
    endfunction

    function automatic exp_t expected(input int unsigned f);
        exp_t e;
        case (f)
            1:       e.fv = 4'b1000;
            2:       e.fv = 4'b0110;
            3:       e.fv = 4'b0110;
            default: e.fv = 4'b0000;
        endcase
        e.ec = (f == 0) ? 3'd0 : (f == 1) ? 3'd1 : 3'd2;
        e.ps = (f == 0);
        return e;
    endfunction

    task automatic run_sweep(input int w, input int unsigned f, input bit poke_busy);
        int unsigned s;
        int unsigned lat;
        int unsigned got_lat;
        logic [11:0] o;
        exp_t e;
        s = (w == 0) ? 2 : 1;
        lat = 4 * (s + 1);
        got_lat = 0;
        fault = f;
        sb.push_back(expected(f));
        start_s[w] = 1'b1;
        tick();
        start_s[w] = 1'b0;
        o = outs(w);
        check("accept_busy_done", {30'd0, o[9], o[8]}, 32'b10);
        check("accept_clear", {25'd0, o[6:0]}, 32'd0);
        for (int k = 1; k <= 200; k++) begin
            if (poke_busy && k == 5) start_s[w] = 1'b1;
            tick();
            start_s[w] = 1'b0;
            o = outs(w);
            if (k < lat && (k % (s + 1)) == 1) begin
                check("stim_ab", {30'd0, o[10], o[11]}, 32'(k / (s + 1)));
                check("busy_mid", {31'd0, o[9]}, 32'd1);
            end
            if (o[8]) begin
                got_lat = k;
                break;
            end
        end
        check("latency", got_lat, lat);
        e = sb.pop_front();
        if (got_lat != 0) begin
            o = outs(w);
            check("fail_vec", {28'd0, o[6:3]}, {28'd0, e.fv});
            check("err_cnt", {29'd0, o[2:0]}, {29'd0, e.ec});
            check("pass", {31'd0, o[7]}, {31'd0, e.ps});
            check("busy_end", {31'd0, o[9]}, 32'd0);
            check("ab_hold", {30'd0, o[11:10]}, 32'b11);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        fault = 0;
        start_s = '0;
        rst_n = 1'b0;
        #12;
        check("reset_dut", {20'd0, outs(0)}, 32'd0);
        check("reset_dut1", {20'd0, outs(1)}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Clean sweep and each fault class on the default-settle instance.
        for (int unsigned f = 0; f < 4; f++) run_sweep(0, f, 1'b0);

        // Start pulse while busy must not disturb the sweep.
        run_sweep(0, 0, 1'b1);

        // Start held high: done is visible for a single cycle before relaunch.
        start_s[0] = 1'b1;
        begin
            int unsigned seen;
            seen = 0;
            for (int k = 0; k < 200; k++) begin
                tick();
                if (done_s[0]) begin
                    seen = 1;
                    break;
                end
            end
            check("held_done_seen", seen, 32'd1);
        end
        tick();
        check("held_relaunch", {30'd0, busy_s[0], done_s[0]}, 32'b10);
        start_s[0] = 1'b0;

        // Reset during the settle of idx2.
        repeat (20) tick();
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        repeat (7) tick();
        check("pre_reset_ab", {30'd0, b_s[0], a_s[0]}, 32'b10);
        rst_n = 1'b0;
        #1;
        check("async_reset", {20'd0, outs(0)}, 32'd0);
        tick();
        check("reset_hold", {20'd0, outs(0)}, 32'd0);
        #3;
        rst_n = 1'b1;
        tick();
        run_sweep(0, 0, 1'b0);

        // SETTLE_CYCLES=1 instance: faulty sweep, then restart from DONE.
        run_sweep(1, 1, 1'b0);
        run_sweep(1, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
